// File: rtl/xevious_dl_ctrl_if.sv
// HPS download bus (ioctl_*) into the controller and the ROM write port (dn_*) out to the core.
interface xevious_dl_ctrl_if;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [16:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_wr;

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      input  dn_addr, dn_data, dn_wr
   );

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      output dn_addr, dn_data, dn_wr
   );
endinterface

// File: rtl/xevious_dl_ctrl.sv
// Xevious ROM/DIP download controller: forwards ROM bytes to the core, latches DIP banks,
// and holds the core in reset until a load has finished and settled.
//
// state     | meaning
// ST_IDLE   | after reset, waiting for an index-0 download; core held
// ST_LOAD   | ROM bytes being forwarded to the core; core held
// ST_SETTLE | download ended, settle timer counting down; core held
// ST_READY  | core released; a new index-0 download restarts the load
module xevious_dl_ctrl #(
   parameter int ROM_BYTES     = 98304,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   xevious_dl_ctrl_if.slave      bus,
   output logic [7:0]            dsw_a,
   output logic [7:0]            dsw_b,
   output logic                  core_reset,
   output logic                  rom_ok,
   output logic                  rom_overflow,
   output logic [17:0]           byte_count
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_SETTLE = 2'd2;
   localparam logic [1:0] ST_READY  = 2'd3;

   localparam int              CW          = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
   localparam logic [24:0]     ROM_LIMIT   = 25'(ROM_BYTES);
   localparam logic [17:0]     ROM_FULL    = 18'(ROM_BYTES);

   logic [1:0]    state;
   logic [CW-1:0] settle_cnt;
   logic [16:0]   dn_addr_q;
   logic [7:0]    dn_data_q;
   logic          dn_wr_q;

   logic rom_start;
   logic rom_in_range;
   logic dip_wr;

   assign rom_start    = bus.ioctl_download && (bus.ioctl_index == 8'd0);
   assign rom_in_range = bus.ioctl_addr < ROM_LIMIT;
   assign dip_wr       = bus.ioctl_download && (bus.ioctl_index == 8'd254) &&
                         bus.ioctl_wr && (bus.ioctl_addr[24:1] == 24'd0);

   assign bus.dn_addr = dn_addr_q;
   assign bus.dn_data = dn_data_q;
   assign bus.dn_wr   = dn_wr_q;
   assign core_reset  = (state != ST_READY);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         settle_cnt   <= '0;
         dn_addr_q    <= '0;
         dn_data_q    <= '0;
         dn_wr_q      <= 1'b0;
         rom_ok       <= 1'b0;
         rom_overflow <= 1'b0;
         byte_count   <= '0;
      end else begin
         dn_wr_q <= 1'b0;
         case (state)
            ST_IDLE, ST_READY: begin
               if (rom_start) begin
                  state        <= ST_LOAD;
                  byte_count   <= '0;
                  rom_overflow <= 1'b0;
                  rom_ok       <= 1'b0;
               end
            end
            ST_LOAD: begin
               // The write in the cycle download falls is still taken; we leave LOAD right after.
               if (bus.ioctl_wr) begin
                  if (rom_in_range) begin
                     dn_addr_q <= bus.ioctl_addr[16:0];
                     dn_data_q <= bus.ioctl_dout;
                     dn_wr_q   <= 1'b1;
                     if (byte_count != '1) byte_count <= byte_count + 18'd1;
                  end else begin
                     rom_overflow <= 1'b1;
                  end
               end
               if (!bus.ioctl_download) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= SETTLE_LOAD;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == '0) begin
                  state  <= ST_READY;
                  rom_ok <= (byte_count == ROM_FULL) && !rom_overflow;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // DIP banks are live in every state and stored inverted (switch on = 0).
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dsw_a <= 8'hFF;
         dsw_b <= 8'hFF;
      end else if (dip_wr) begin
         if (bus.ioctl_addr[0]) dsw_b <= ~bus.ioctl_dout;
         else                   dsw_a <= ~bus.ioctl_dout;
      end
   end

endmodule

// File: tb/tb_xevious_dl_ctrl.sv
// Directed bench for xevious_dl_ctrl; ROM image length scaled to 2048 bytes to keep runs short.
module tb_xevious_dl_ctrl;
   localparam int ROM_B  = 2048;
   localparam int SETTLE = 16;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  dsw_a, dsw_b;
   logic        core_reset, rom_ok, rom_overflow;
   logic [17:0] byte_count;

   xevious_dl_ctrl_if bus ();

   xevious_dl_ctrl #(.ROM_BYTES(ROM_B), .SETTLE_CYCLES(SETTLE)) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .bus          (bus),
      .dsw_a        (dsw_a),
      .dsw_b        (dsw_b),
      .core_reset   (core_reset),
      .rom_ok       (rom_ok),
      .rom_overflow (rom_overflow),
      .byte_count   (byte_count)
   );

   always #5 clk_sys = ~clk_sys;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;

   always @(posedge clk_sys) if (bus.dn_wr) pulses <= pulses + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] dat(input int i);
      return 8'(i) ^ 8'h5A;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_dn_addr"}, 32'(bus.dn_addr), 32'h0);
      chk({tag, "_dn_data"}, 32'(bus.dn_data), 32'h0);
      chk({tag, "_dn_wr"}, 32'(bus.dn_wr), 32'h0);
      chk({tag, "_dsw_a"}, 32'(dsw_a), 32'hFF);
      chk({tag, "_dsw_b"}, 32'(dsw_b), 32'hFF);
      chk({tag, "_core_reset"}, 32'(core_reset), 32'h1);
      chk({tag, "_rom_ok"}, 32'(rom_ok), 32'h0);
      chk({tag, "_rom_overflow"}, 32'(rom_overflow), 32'h0);
      chk({tag, "_byte_count"}, 32'(byte_count), 32'h0);
   endtask

   // Streams n writes (one per cycle); each is checked one cycle after it is driven.
   task automatic rom_load(input int n, input bit over, input bit bnd,
                           output int settle, output int errs);
      errs = 0;
      @(negedge clk_sys);
      bus.ioctl_download = 1'b1;
      bus.ioctl_index    = 8'd0;
      bus.ioctl_wr       = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk_sys);
         if (i > 0 && (!bus.dn_wr || bus.dn_addr != 17'(i - 1) ||
                       bus.dn_data != dat(i - 1) || !core_reset)) errs++;
         bus.ioctl_wr   = 1'b1;
         bus.ioctl_addr = 25'(i);
         bus.ioctl_dout = dat(i);
         if (bnd && i == n - 1) bus.ioctl_download = 1'b0;
      end
      @(negedge clk_sys);
      if (!bus.dn_wr || bus.dn_addr != 17'(n - 1) || bus.dn_data != dat(n - 1) || !core_reset)
         errs++;
      if (over) begin
         bus.ioctl_addr = 25'(ROM_B);
         bus.ioctl_dout = 8'hEE;
         @(negedge clk_sys);
         if (bus.dn_wr) errs++;
      end
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_download = 1'b0;
      settle = bnd ? 1 : 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk_sys);
         if (!core_reset) break;
         settle++;
      end
   endtask

   task automatic dip_write(input logic [24:0] a, input logic [7:0] d);
      @(negedge clk_sys);
      bus.ioctl_download = 1'b1;
      bus.ioctl_index    = 8'd254;
      bus.ioctl_wr       = 1'b1;
      bus.ioctl_addr     = a;
      bus.ioctl_dout     = d;
      @(negedge clk_sys);
      bus.ioctl_wr = 1'b0;
      @(negedge clk_sys);
   endtask

   int settle, errs, p0;

   initial begin
      bus.ioctl_download = 1'b0;
      bus.ioctl_index    = 8'd0;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_addr     = '0;
      bus.ioctl_dout     = '0;
      repeat (3) @(negedge clk_sys);
      chk_reset_vals("rst");
      reset_n = 1'b1;
      repeat (3) @(negedge clk_sys);
      chk("idle_core_reset", 32'(core_reset), 32'h1);

      // full load
      p0 = pulses;
      rom_load(ROM_B, 1'b0, 1'b0, settle, errs);
      chk("full_wr_errs", 32'(errs), 32'h0);
      chk("full_pulses", 32'(pulses - p0), 32'(ROM_B));
      chk("full_settle", 32'(settle), 32'(SETTLE));
      chk("full_count", 32'(byte_count), 32'(ROM_B));
      chk("full_rom_ok", 32'(rom_ok), 32'h1);
      chk("full_overflow", 32'(rom_overflow), 32'h0);

      // DIP load while READY
      dip_write(25'd0, 8'h3C);
      dip_write(25'd1, 8'h81);
      chk("dip_a", 32'(dsw_a), 32'hC3);
      chk("dip_b", 32'(dsw_b), 32'h7E);
      dip_write(25'd2, 8'h55);
      chk("dip_a_addr2", 32'(dsw_a), 32'hC3);
      chk("dip_b_addr2", 32'(dsw_b), 32'h7E);
      chk("dip_core_reset", 32'(core_reset), 32'h0);
      chk("dip_rom_ok", 32'(rom_ok), 32'h1);
      bus.ioctl_download = 1'b0;

      // other index and writes without download are ignored
      p0 = pulses;
      @(negedge clk_sys);
      bus.ioctl_download = 1'b1;
      bus.ioctl_index    = 8'd7;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_sys);
         bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(i); bus.ioctl_dout = 8'h11;
      end
      @(negedge clk_sys);
      bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0; bus.ioctl_index = 8'd0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_sys);
         bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(i); bus.ioctl_dout = 8'h22;
      end
      @(negedge clk_sys);
      bus.ioctl_wr = 1'b0;
      repeat (20) @(negedge clk_sys);
      chk("ign_pulses", 32'(pulses - p0), 32'h0);
      chk("ign_core_reset", 32'(core_reset), 32'h0);
      chk("ign_count", 32'(byte_count), 32'(ROM_B));

      // overflow load
      p0 = pulses;
      rom_load(ROM_B, 1'b1, 1'b0, settle, errs);
      chk("ovf_wr_errs", 32'(errs), 32'h0);
      chk("ovf_pulses", 32'(pulses - p0), 32'(ROM_B));
      chk("ovf_count", 32'(byte_count), 32'(ROM_B));
      chk("ovf_flag", 32'(rom_overflow), 32'h1);
      chk("ovf_rom_ok", 32'(rom_ok), 32'h0);

      // short load
      rom_load(1000, 1'b0, 1'b0, settle, errs);
      chk("short_wr_errs", 32'(errs), 32'h0);
      chk("short_count", 32'(byte_count), 32'd1000);
      chk("short_rom_ok", 32'(rom_ok), 32'h0);
      chk("short_overflow", 32'(rom_overflow), 32'h0);
      chk("short_core_reset", 32'(core_reset), 32'h0);

      // last write in the same cycle download falls
      rom_load(ROM_B, 1'b0, 1'b1, settle, errs);
      chk("bnd_wr_errs", 32'(errs), 32'h0);
      chk("bnd_settle", 32'(settle), 32'(SETTLE));
      chk("bnd_count", 32'(byte_count), 32'(ROM_B));
      chk("bnd_rom_ok", 32'(rom_ok), 32'h1);

      // reset in the middle of a load
      @(negedge clk_sys);
      bus.ioctl_download = 1'b1;
      bus.ioctl_index    = 8'd0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk_sys);
         bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(i); bus.ioctl_dout = dat(i);
      end
      @(negedge clk_sys);
      bus.ioctl_wr = 1'b0;
      chk("mid_count", 32'(byte_count), 32'd500);
      #2 reset_n = 1'b0;
      #1 chk_reset_vals("mid_rst");
      @(negedge clk_sys);
      bus.ioctl_download = 1'b0;
      reset_n = 1'b1;
      repeat (30) @(negedge clk_sys);
      chk("mid_idle_core_reset", 32'(core_reset), 32'h1);
      chk("mid_idle_count", 32'(byte_count), 32'h0);
      rom_load(ROM_B, 1'b0, 1'b0, settle, errs);
      chk("reload_wr_errs", 32'(errs), 32'h0);
      chk("reload_count", 32'(byte_count), 32'(ROM_B));
      chk("reload_rom_ok", 32'(rom_ok), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
